// File: rtl/vend_txn_sequencer.sv
// vend_txn_sequencer
//   Transaction controller for the vending-machine datapath. Accumulates coin
//   credit, checks a product selection against its price, drives the
//   dispenser through a req/ready/done handshake and then returns change one
//   unit per pulse, with a one-cycle gap between pulses.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   tick         one-cycle timebase enable; advances the CREDIT timeout
//   coin         one-cycle pulse, +1 credit unit
//   cancel       level, refund request (honoured in CREDIT only)
//   sel_valid    one-cycle selection strobe
//   sel_prod     product code, sampled with sel_valid
//   disp_ready   dispenser accepts the request
//   disp_done    one-cycle pulse, dispensing finished
//   disp_req     dispense request, high for the whole DISPENSE state
//   disp_prod    latched product code presented to the dispenser
//   change_pulse one pulse per returned credit unit
//   coin_reject  one-cycle pulse, the cycle after a coin was refused
//   err_funds    one-cycle pulse, the cycle after an unaffordable selection
//   credit       current credit
//   busy         high in DISPENSE, WAIT_DONE and CHANGE
module vend_txn_sequencer #(
  parameter int unsigned CREDIT_W      = 3,
  parameter int unsigned PRICE0        = 2,
  parameter int unsigned PRICE1        = 3,
  parameter int unsigned PRICE2        = 4,
  parameter int unsigned PRICE3        = 5,
  parameter int unsigned TIMEOUT_TICKS = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                coin,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [1:0]          sel_prod,
  input  logic                disp_ready,
  input  logic                disp_done,
  output logic                disp_req,
  output logic [1:0]          disp_prod,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                err_funds,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] P0         = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1         = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2         = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3         = CREDIT_W'(PRICE3);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CREDIT    = 3'd1,
    ST_DISPENSE  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHANGE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [TMO_W-1:0]    tmo_inc;
  logic [1:0]          prod_q, prod_d;
  logic                change_pulse_q, change_pulse_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_funds_q, err_funds_d;
  logic                disp_req_q, disp_req_d;
  logic                busy_q, busy_d;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] p);
    logic [CREDIT_W-1:0] r;
    case (p)
      2'd0:    r = P0;
      2'd1:    r = P1;
      2'd2:    r = P2;
      default: r = P3;
    endcase
    return r;
  endfunction

  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    tmo_d          = tmo_q;
    prod_d         = prod_q;
    change_pulse_d = 1'b0;
    coin_reject_d  = 1'b0;
    err_funds_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Zero credit can never afford a product; a coin arriving with the
        // strobe loses to it, as in CREDIT.
        if (sel_valid) begin
          err_funds_d   = 1'b1;
          coin_reject_d = coin;
        end else if (coin) begin
          credit_d = CREDIT_ONE;
          state_d  = ST_CREDIT;
        end
      end

      ST_CREDIT: begin
        // sel_valid > coin > cancel; the timeout only advances on a quiet tick.
        if (sel_valid) begin
          coin_reject_d = coin;
          if (credit_q >= price_of(sel_prod)) begin
            prod_d  = sel_prod;
            state_d = ST_DISPENSE;
          end else begin
            err_funds_d = 1'b1;
            tmo_d       = '0;
          end
        end else if (coin) begin
          tmo_d = '0;
          if (credit_q == CREDIT_MAX) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = credit_q + 1'b1;
          end
        end else if (cancel) begin
          state_d = ST_CHANGE;
        end else if (tick) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LAST) begin
            state_d = ST_CHANGE;
          end
        end
      end

      ST_DISPENSE: begin
        coin_reject_d = coin;
        if (disp_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        coin_reject_d = coin;
        if (disp_done) begin
          credit_d = credit_q - price_of(prod_q);
          state_d  = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        // The registered pulse doubles as the phase bit: a unit is paid out
        // only on the cycle after a gap, so pulses land every other cycle.
        coin_reject_d = coin;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (!change_pulse_q) begin
          change_pulse_d = 1'b1;
          credit_d       = credit_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counter is only meaningful inside CREDIT; holding it at zero elsewhere
    // also gives the clear-on-entry behaviour.
    if (state_d != ST_CREDIT) begin
      tmo_d = '0;
    end
  end

  // Decoded from the next state so the registered outputs line up with state.
  assign disp_req_d = (state_d == ST_DISPENSE);
  assign busy_d     = (state_d == ST_DISPENSE) || (state_d == ST_WAIT_DONE) ||
                      (state_d == ST_CHANGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      tmo_q          <= '0;
      prod_q         <= '0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      err_funds_q    <= 1'b0;
      disp_req_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      tmo_q          <= tmo_d;
      prod_q         <= prod_d;
      change_pulse_q <= change_pulse_d;
      coin_reject_q  <= coin_reject_d;
      err_funds_q    <= err_funds_d;
      disp_req_q     <= disp_req_d;
      busy_q         <= busy_d;
    end
  end

  assign disp_req     = disp_req_q;
  assign disp_prod    = prod_q;
  assign change_pulse = change_pulse_q;
  assign coin_reject  = coin_reject_q;
  assign err_funds    = err_funds_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule

// File: doc/vend_txn_sequencer.md
Name: vend_txn_sequencer

Overview:
- Transaction controller for the vending-machine datapath.
- Accumulates coin credit and checks a product selection against a per-product price.
- Sequences the dispenser with a req/ready/done handshake, then returns change one unit per pulse.
- Runs on the system clock; timeout counting is gated by the one-cycle `tick` enable from the clock prescaler.

Parameters:
- CREDIT_W, 3: credit register width. Max credit = 2^CREDIT_W-1.
- PRICE0, 2: price of product 0 in coin units. Must be at least 1 and at most the max credit.
- PRICE1, 3: price of product 1 (same constraint).
- PRICE2, 4: price of product 2 (same constraint).
- PRICE3, 5: price of product 3 (same constraint).
- TIMEOUT_TICKS, 15: idle `tick` count in CREDIT before an automatic refund. Must be at least 1.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  single-cycle timebase enable from the prescaler
- coin  in  1  single-cycle pulse, +1 credit unit
- cancel  in  1  level, request a refund
- sel_valid  in  1  single-cycle selection strobe
- sel_prod  in  2  product code, sampled when sel_valid=1
- disp_ready  in  1  dispenser accepts the request
- disp_done  in  1  single-cycle pulse, dispensing finished
- disp_req  out  1  dispense request
- disp_prod  out  2  product code to the dispenser
- change_pulse  out  1  one pulse per returned unit
- coin_reject  out  1  one-cycle pulse, coin not accepted
- err_funds  out  1  one-cycle pulse, credit insufficient
- credit  out  CREDIT_W  current credit
- busy  out  1  high in DISPENSE, WAIT_DONE, CHANGE

Behaviour:
- Reset: state=IDLE. All outputs are 0, credit=0, the timeout counter is 0, and the latched product is 0.
- Reset asserted mid-transaction aborts immediately. No refund; credit is lost.
- States: IDLE, CREDIT, DISPENSE, WAIT_DONE, CHANGE.
- IDLE:
  - coin → credit=1, go to CREDIT.
  - sel_valid → err_funds pulse next cycle.
  - cancel is ignored.
- CREDIT:
  - coin: credit+1. If credit is already at max, credit is held and coin_reject pulses. Either way the timeout counter clears.
  - sel_valid with credit ≥ PRICE[sel_prod]: latch sel_prod, go to DISPENSE.
  - sel_valid with insufficient credit: err_funds pulses for 1 cycle, stay in CREDIT, timeout counter clears.
  - cancel (without sel_valid) → CHANGE.
  - Priority when several occur in the same cycle: sel_valid > coin > cancel. The lower-priority coin is rejected (coin_reject).
  - Timeout: the counter increments on each tick. When it reaches TIMEOUT_TICKS the block goes to CHANGE.
- DISPENSE:
  - disp_req=1 and disp_prod=latched product; both held stable until the cycle where disp_ready=1.
  - In that handshake cycle, go to WAIT_DONE and drop disp_req the next cycle.
  - cancel is ignored.
- WAIT_DONE: on disp_done, credit ← credit − price, computed at CREDIT_W width with no underflow (guaranteed by the check), then go to CHANGE. There is no timeout.
- CHANGE:
  - If credit=0, go to IDLE next cycle with no pulse.
  - Otherwise change_pulse=1 for one cycle and credit decrements, then change_pulse=0 for one cycle. So pulses occur every other cycle and stay distinguishable downstream.
  - Go to IDLE the cycle after credit reaches 0.
- Any coin in DISPENSE, WAIT_DONE or CHANGE → coin_reject pulse, credit unchanged.
- The timeout counter clears on entry to CREDIT and is inactive outside CREDIT.
- busy is a registered decode of state.
- err_funds and coin_reject are registered, asserted the cycle after the cause.

Test Plan:
- Reset mid-DISPENSE with credit=4: assert rst_n=0 → same cycle all outputs 0, state IDLE. After release, one coin → credit=1.
- 3 coins, select prod1 (price 3), disp_ready held 0 for 4 cycles then 1, disp_done 2 cycles later:
  - disp_req high exactly until the handshake, disp_prod=1 stable throughout.
  - Final credit=0, no change_pulse, return to IDLE.
- 5 coins, select prod0 (price 2), complete handshake → exactly 3 change_pulse, spaced 2 cycles apart, credit 3→0, then IDLE.
- 2 coins, select prod3 (price 5) → err_funds pulses once, credit stays 2. Then 3 coins and select prod3 → dispense, 0 change.
- 7 coins → credit=7. 8th coin → coin_reject, credit=7. cancel → 7 change_pulse, then IDLE.
- 1 coin, then 15 ticks with no activity → CHANGE, 1 change_pulse. A coin inserted at tick 14 must restart the count and delay the timeout.
